// File: rtl/decode_sequencer_pkg.sv
// Shared definitions for the decode sequencer: FSM state encoding, RISC-V
// opcode values, immediate-format select codes, trap cause codes and the
// classifier result payload.
package decode_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_I_TYPE = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE = 7'b0100011;
  localparam logic [6:0] OP_R_IMM  = 7'b0010011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;

  localparam logic [2:0] FMT_NONE   = 3'd0;
  localparam logic [2:0] FMT_U      = 3'd1;
  localparam logic [2:0] FMT_J      = 3'd2;
  localparam logic [2:0] FMT_I_JALR = 3'd3;
  localparam logic [2:0] FMT_B      = 3'd4;
  localparam logic [2:0] FMT_I_LOAD = 3'd5;
  localparam logic [2:0] FMT_S      = 3'd6;
  localparam logic [2:0] FMT_R_IMM  = 3'd7;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

  typedef struct packed {
    logic       legal;
    logic [2:0] fmt;
  } op_class_t;

endpackage

// File: rtl/decode_sequencer_opcode_classifier.sv
// Combinational opcode classifier: maps instr[6:0] to an immediate format
// and a legality flag.
//   opcode : instr[6:0] of the latched instruction
//   cls_c  : {legal, fmt}; illegal opcodes report FMT_NONE
module opcode_classifier
  import decode_sequencer_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls_c
);

  always_comb begin
    cls_c = '{legal: 1'b0, fmt: FMT_NONE};
    // Compressed / non-32-bit encodings are never legal here.
    if (opcode[1:0] == 2'b11) begin
      case (opcode)
        OP_LUI,
        OP_AUIPC:  cls_c = '{legal: 1'b1, fmt: FMT_U};
        OP_JAL:    cls_c = '{legal: 1'b1, fmt: FMT_J};
        OP_JALR:   cls_c = '{legal: 1'b1, fmt: FMT_I_JALR};
        OP_B_TYPE: cls_c = '{legal: 1'b1, fmt: FMT_B};
        OP_I_TYPE: cls_c = '{legal: 1'b1, fmt: FMT_I_LOAD};
        OP_S_TYPE: cls_c = '{legal: 1'b1, fmt: FMT_S};
        OP_R_IMM:  cls_c = '{legal: 1'b1, fmt: FMT_R_IMM};
        OP_R_TYPE: cls_c = '{legal: 1'b1, fmt: FMT_NONE};
        default:   cls_c = '{legal: 1'b0, fmt: FMT_NONE};
      endcase
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Fetch/decode/issue sequencer with fault trapping.
//   clk, rst_n               : clock, async active-low reset
//   imem_req/imem_addr       : fetch request and address (address is pc_q)
//   imem_valid/imem_rdata    : fetch response
//   issue_valid/issue_ready  : decoded-instruction handshake to execute
//   instr_q, fmt_sel, pc_q   : latched instruction, immediate format, its PC
//   redirect_valid/_pc       : taken branch/jump, sampled on the handshake only
//   trap, trap_cause         : halted on fault and why
//   trap_clear               : resume from trap
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [XLEN-1:0]  instr_q,
  output logic [2:0]       fmt_sel,
  output logic [XLEN-1:0]  pc_q,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  input  logic             trap_clear
);

  // Count value seen in the last FETCH cycle allowed before timing out.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pc_d, instr_d;
  logic [2:0]       fmt_d;
  logic [1:0]       cause_d;
  logic             imem_req_d, issue_valid_d, trap_d;
  op_class_t        cls_c;

  opcode_classifier u_classifier (
    .opcode (instr_q[6:0]),
    .cls_c  (cls_c)
  );

  assign imem_addr = pc_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fmt_d   = fmt_sel;
    cause_d = trap_cause;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_FETCH: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (imem_valid) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        fmt_d = cls_c.fmt;
        if (cls_c.legal) begin
          state_d = ST_ISSUE;
        end else begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end
      end
      ST_ISSUE: begin
        if (issue_ready) begin
          if (!redirect_valid) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = ST_FETCH;
          end else if (redirect_pc[1:0] == 2'b00) begin
            pc_d    = redirect_pc;
            state_d = ST_FETCH;
          end else begin
            cause_d = CAUSE_MISALIGN;
            state_d = ST_TRAP;
          end
        end
      end
      ST_TRAP: begin
        // Illegal instructions are skipped; other faults retry the same PC.
        if (trap_clear) begin
          if (trap_cause == CAUSE_ILLEGAL) pc_d = pc_q + XLEN'(4);
          cause_d = CAUSE_NONE;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    imem_req_d    = 1'b0;
    issue_valid_d = 1'b0;
    trap_d        = 1'b0;
    case (state_d)
      ST_FETCH: imem_req_d    = 1'b1;
      ST_ISSUE: issue_valid_d = 1'b1;
      ST_TRAP:  trap_d        = 1'b1;
      default:  ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      fmt_sel     <= FMT_NONE;
      trap_cause  <= CAUSE_NONE;
      imem_req    <= 1'b0;
      issue_valid <= 1'b0;
      trap        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      fmt_sel     <= fmt_d;
      trap_cause  <= cause_d;
      imem_req    <= imem_req_d;
      issue_valid <= issue_valid_d;
      trap        <= trap_d;
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: a driver issues directed then random
// transactions and pushes expectations; a monitor pops and compares on DUT events.
module tb_decode_sequencer;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int unsigned FETCH_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [31:0] instr_q;
  logic [2:0]  fmt_sel;
  logic [31:0] pc_q;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        trap_clear = 1'b0;

  decode_sequencer #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .instr_q(instr_q), .fmt_sel(fmt_sel), .pc_q(pc_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap(trap), .trap_cause(trap_cause), .trap_clear(trap_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  fmt;
  } iss_t;

  iss_t        exp_iss[$];
  logic [31:0] exp_addr[$];
  logic [1:0]  exp_cause[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mpc = RESET_PC;

  // Legal opcodes and their immediate formats, straight from the opcode list.
  logic [6:0] op_tab  [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [2:0] fmt_tab [9] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic void model_decode(input logic [31:0] ins, output bit legal,
                                       output logic [2:0] fmt);
    legal = 1'b0;
    fmt   = 3'd0;
    if (ins[1:0] == 2'b11)
      for (int i = 0; i < 9; i++)
        if (ins[6:0] == op_tab[i]) begin
          legal = 1'b1;
          fmt   = fmt_tab[i];
        end
  endfunction

  function automatic logic [31:0] rand_instr(input bit want_legal);
    logic [31:0] ins;
    bit          lg;
    logic [2:0]  f;
    if (want_legal) begin
      ins = ($urandom() & 32'hFFFF_FF80) | {25'd0, op_tab[$urandom_range(0, 8)]};
    end else begin
      ins = $urandom();
      model_decode(ins, lg, f);
      while (lg) begin
        ins = $urandom();
        model_decode(ins, lg, f);
      end
    end
    return ins;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return imem_req;
      1:       return issue_valid;
      default: return trap;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n = 0;
    while (!sig_sel(which)) begin
      tick();
      n++;
      if (n > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_%s: not asserted within 60 cycles, required asserted", name);
        finish_test();
      end
    end
  endtask

  task automatic clear_trap();
    wait_sig(2, "trap");
    repeat ($urandom_range(0, 3)) tick();
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
  endtask

  // d < 0 means never respond (timeout). rkind: 0 none, 1 aligned redirect, 2 misaligned.
  task automatic do_txn(input int d, input logic [31:0] ins, input int rwait,
                        input int rkind, input logic [31:0] tgt);
    bit         legal;
    logic [2:0] fmt;
    wait_sig(0, "imem_req");
    if (d < 0) begin
      exp_cause.push_back(2'b10);
      imem_valid = 1'b0;
      clear_trap();
      exp_addr.push_back(mpc);
      return;
    end
    repeat (d) begin
      imem_valid     = 1'b0;
      trap_clear     = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom();
      tick();
    end
    trap_clear     = 1'b0;
    redirect_valid = 1'b0;
    model_decode(ins, legal, fmt);
    if (legal) exp_iss.push_back('{pc: mpc, instr: ins, fmt: fmt});
    else       exp_cause.push_back(2'b01);
    imem_valid = 1'b1;
    imem_rdata = ins;
    tick();
    imem_valid = 1'b0;
    imem_rdata = $urandom();
    if (!legal) begin
      clear_trap();
      mpc = mpc + 32'd4;
      exp_addr.push_back(mpc);
      return;
    end
    wait_sig(1, "issue_valid");
    repeat (rwait) begin
      issue_ready    = 1'b0;
      redirect_valid = 1'($urandom_range(0, 1));
      trap_clear     = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom();
      tick();
    end
    trap_clear     = 1'b0;
    issue_ready    = 1'b1;
    redirect_valid = (rkind != 0);
    redirect_pc    = tgt;
    if (rkind == 2) exp_cause.push_back(2'b11);
    tick();
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    case (rkind)
      0:       mpc = mpc + 32'd4;
      1:       mpc = tgt;
      default: clear_trap();
    endcase
    exp_addr.push_back(mpc);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    logic prev_req = 1'b0, prev_iv = 1'b0, prev_trap = 1'b0;
    int   cyc = 0, acc_cyc = -100, req_run = 0;
    iss_t cur;
    logic [1:0] cur_cause = 2'b00;
    cur = '{pc: '0, instr: '0, fmt: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0; prev_iv = 1'b0; prev_trap = 1'b0; req_run = 0;
      end else begin
        cyc++;
        if (imem_req && !prev_req) begin
          req_run = 0;
          if (exp_addr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_unexpected: addr %h, required no fetch", imem_addr);
          end else chk("fetch_addr", imem_addr, exp_addr.pop_front());
        end
        if (imem_req) begin
          if (imem_valid) acc_cyc = cyc;
          else            req_run++;
        end
        if (issue_valid && !prev_iv) begin
          if (exp_iss.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL issue_unexpected: instr %h, required no issue", instr_q);
          end else begin
            cur = exp_iss.pop_front();
            chk("issue_instr", instr_q, cur.instr);
            chk("issue_fmt", 32'(fmt_sel), 32'(cur.fmt));
            chk("issue_pc", pc_q, cur.pc);
            chk("issue_latency", 32'(cyc - acc_cyc), 32'd2);
          end
        end else if (issue_valid) begin
          chk("hold_instr", instr_q, cur.instr);
          chk("hold_fmt", 32'(fmt_sel), 32'(cur.fmt));
          chk("hold_pc", pc_q, cur.pc);
        end
        if (trap && !prev_trap) begin
          if (exp_cause.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL trap_unexpected: cause %h, required no trap", trap_cause);
          end else begin
            cur_cause = exp_cause.pop_front();
            chk("trap_cause", 32'(trap_cause), 32'(cur_cause));
            if (cur_cause == 2'b10)
              chk("timeout_cycles", 32'(req_run), 32'(FETCH_TIMEOUT));
            chk("trap_outs", {30'd0, imem_req, issue_valid}, 32'd0);
          end
        end else if (trap) begin
          chk("trap_hold", 32'(trap_cause), 32'(cur_cause));
        end
        prev_req  = imem_req;
        prev_iv   = issue_valid;
        prev_trap = trap;
      end
    end
  end

  task automatic chk_reset_outs();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_trap", {30'd0, trap, 1'b0} | 32'(trap_cause), 32'd0);
    chk("rst_pc", pc_q, RESET_PC);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", instr_q, 32'd0);
    chk("rst_fmt", 32'(fmt_sel), 32'd0);
  endtask

  // Driver
  initial begin : driver
    int          kind, rk, d;
    logic [31:0] tgt, ins;
    imem_valid = 1'b1;
    repeat (3) tick();
    chk_reset_outs();
    // Release with a stale response still asserted; it must be ignored.
    exp_addr.push_back(RESET_PC);
    rst_n = 1'b1;
    tick();
    imem_valid = 1'b0;

    do_txn(2, 32'h0000_0537, 5, 0, 32'h0);          // LUI, held 5 cycles
    do_txn(0, 32'h0010_0093, 0, 1, 32'h0000_0100);  // redirect to 0x100
    do_txn(1, 32'h0000_006F, 0, 2, 32'h0000_0102);  // misaligned redirect
    do_txn(0, 32'h0000_0000, 0, 0, 32'h0);          // illegal
    do_txn(-1, 32'h0, 0, 0, 32'h0);                 // fetch timeout
    do_txn(0, 32'h0000_0063, 0, 1, 32'hFFFF_FFFC);  // jump to top of memory
    do_txn(14, 32'h0000_2023, 1, 0, 32'h0);         // last-cycle response, PC wraps

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      rk   = $urandom_range(0, 3);
      d    = ($urandom_range(0, 4) == 0) ? 14 : $urandom_range(0, 3);
      if (rk == 2)      tgt = $urandom() | 32'(1 + $urandom_range(0, 2));
      else if (rk == 3) tgt = 32'hFFFF_FFFC;
      else              tgt = $urandom() & 32'hFFFF_FFFC;
      if (rk == 3) rk = 1;
      if (kind == 0)      do_txn(-1, 32'h0, 0, 0, 32'h0);
      else if (kind == 1) do_txn(d, rand_instr(1'b0), 0, 0, 32'h0);
      else                do_txn(d, rand_instr(1'b1), $urandom_range(0, 3),
                                 ($urandom_range(0, 1) == 0) ? 0 : rk, tgt);
    end

    // Reset pulsed while an instruction is being offered.
    wait_sig(0, "imem_req");
    ins = rand_instr(1'b1);
    begin
      bit lg; logic [2:0] f;
      model_decode(ins, lg, f);
      exp_iss.push_back('{pc: mpc, instr: ins, fmt: f});
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    tick();
    imem_valid = 1'b0;
    wait_sig(1, "issue_valid");
    tick();
    tick();
    rst_n      = 1'b0;
    imem_valid = 1'b1;
    #1;
    chk_reset_outs();
    exp_iss.delete();
    exp_addr.delete();
    exp_cause.delete();
    tick();
    tick();
    mpc = RESET_PC;
    exp_addr.push_back(RESET_PC);
    rst_n = 1'b1;
    tick();
    imem_valid = 1'b0;
    do_txn(1, 32'h0000_0537, 0, 0, 32'h0);

    repeat (3) tick();
    chk("drain_queues", 32'(exp_iss.size() + exp_addr.size() + exp_cause.size()), 32'd0);
    finish_test();
  end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: FETCH_TIMEOUT, 15, max FETCH cycles without imem_valid before trap (range 1..255).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  fetch request.
REQ-007 imem_addr  output  32  fetch address; equals pc_q.
REQ-008 imem_valid  input  1  fetch data valid.
REQ-009 imem_rdata  input  32  fetched instruction.
REQ-010 issue_valid  output  1  decoded instruction offered to execute.
REQ-011 issue_ready  input  1  execute accepts.
REQ-012 instr_q  output  32  latched instruction, feeds immediate generation.
REQ-013 fmt_sel  output  3  immediate format: 0 none/R, 1 U (LUI/AUIPC), 2 J (JAL), 3 I-JALR, 4 B, 5 I-load, 6 S, 7 R_IMM.
REQ-014 pc_q  output  32  PC of the current instruction.
REQ-015 redirect_valid  input  1  branch/jump taken.
REQ-016 redirect_pc  input  32  target PC.
REQ-017 trap  output  1  sequencer halted on fault.
REQ-018 trap_cause  output  2  01 illegal opcode, 10 fetch timeout, 11 misaligned redirect.
REQ-019 trap_clear  input  1  resume from TRAP.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DECODE, ISSUE, TRAP; IDLE->FETCH unconditionally after one cycle.
REQ-021 FETCH: imem_req=1; on imem_valid, instr_q<=imem_rdata, timeout counter cleared, ->DECODE.
REQ-022 FETCH: counter increments each cycle without imem_valid; at FETCH_TIMEOUT, ->TRAP cause 10, imem_req drops; imem_valid in that same cycle wins over timeout.
REQ-023 DECODE: exactly one cycle; fmt_sel registered from instr_q[6:0] via the shared opcode macros.
REQ-024 DECODE: opcode outside {LUI, AUIPC, JAL, JALR, B_TYPE, I_TYPE, S_TYPE, R_IMM, R_TYPE} or instr_q[1:0]!=2'b11 -> TRAP cause 01; else ->ISSUE.
REQ-025 Latency: imem_valid in cycle t -> issue_valid asserted in cycle t+2.
REQ-026 ISSUE: issue_valid=1; instr_q, fmt_sel, pc_q held stable until issue_valid&&issue_ready.
REQ-027 On handshake without redirect_valid: pc_q<=pc_q+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), ->FETCH.
REQ-028 On handshake with redirect_valid: redirect_pc[1:0]==0 -> pc_q<=redirect_pc, ->FETCH; else pc_q unchanged, ->TRAP cause 11.
REQ-029 redirect_valid outside the ISSUE handshake cycle SHALL be ignored.
REQ-030 TRAP: trap=1, trap_cause held, imem_req=0, issue_valid=0; trap_clear -> FETCH with pc_q+4 for cause 01, pc_q unchanged for causes 10/11; trap and trap_cause clear on exit.
REQ-031 trap_clear outside TRAP SHALL be ignored.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, pc_q=RESET_PC, instr_q=0, fmt_sel=0, counter=0, imem_req=0, issue_valid=0, trap=0, trap_cause=0.
REQ-033 Reset mid-FETCH or mid-ISSUE SHALL abandon the transaction; a late imem_valid after release but before FETCH SHALL be ignored.

Structure
REQ-034 Opcode macros, fmt_sel codes, trap_cause codes and state encodings SHALL live in the shared parameters.v header.
REQ-035 Opcode-to-format/legality decoding SHALL be a combinational sub-module opcode_classifier; FSM, counter and PC registers in decode_sequencer.

Verification
REQ-036 Reset release, imem_valid after 2 cycles with 32'h0000_0537 (LUI) -> fmt_sel=1, issue_valid 2 cycles after imem_valid, pc_q=0.
REQ-037 Issue held with issue_ready=0 for 5 cycles -> instr_q/fmt_sel/pc_q stable; on ready, next imem_addr=4.
REQ-038 Handshake with redirect_valid=1, redirect_pc=32'h100 -> imem_addr=32'h100; redirect_pc=32'h102 -> trap=1, cause 11.
REQ-039 imem_rdata=32'h0000_0000 -> trap cause 01; trap_clear -> FETCH at pc_q+4.
REQ-040 No imem_valid for 15 FETCH cycles -> trap cause 10, imem_req=0; trap_clear -> refetch same address.
REQ-041 pc_q=32'hFFFF_FFFC, handshake -> imem_addr=0; rst_n pulsed mid-ISSUE -> all outputs reset values, pc_q=RESET_PC.
